// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage, one bit per cycle, owning HI/LO.
// Also services MTHI/MTLO writes and raises a stall while an operation is in flight.
module ex_muldiv_unit #(
  parameter int DATA_SZ = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_start,
  input  logic [1:0]         i_op,
  input  logic [DATA_SZ-1:0] i_rs_data,
  input  logic [DATA_SZ-1:0] i_rt_data,
  input  logic               i_hilo_read,
  input  logic               i_mthi,
  input  logic               i_mtlo,
  output logic [DATA_SZ-1:0] o_hi,
  output logic [DATA_SZ-1:0] o_lo,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_stall,
  output logic [1:0]         o_state
);

  localparam int CW = $clog2(DATA_SZ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_SZ-1:0]   a_q, a_d, b_q, b_d, araw_q, araw_d;
  logic [DATA_SZ-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*DATA_SZ-1:0] acc_q, acc_d;
  logic                 is_div_q, is_div_d, neg_q, neg_d;
  logic                 dneg_q, dneg_d, bzero_q, bzero_d, done_q, done_d;

  logic                 is_signed;
  logic [DATA_SZ-1:0]   a_mag, b_mag;
  logic [DATA_SZ:0]     mul_sum;
  logic [DATA_SZ:0]     rem_sh;
  logic [DATA_SZ+1:0]   rem_diff;
  logic [2*DATA_SZ-1:0] prod_fix;
  logic [DATA_SZ-1:0]   quo_fix, rem_fix;

  always_comb begin
    is_signed = ~i_op[0];
    a_mag     = (is_signed && i_rs_data[DATA_SZ-1]) ? -i_rs_data : i_rs_data;
    b_mag     = (is_signed && i_rt_data[DATA_SZ-1]) ? -i_rt_data : i_rt_data;
    // Multiply: add into the upper half, then shift the whole product right.
    mul_sum   = {1'b0, acc_q[2*DATA_SZ-1:DATA_SZ]} + {1'b0, (b_q[0] ? a_q : '0)};
    // Divide: upper half is the partial remainder, lower half collects quotient bits.
    rem_sh    = {acc_q[2*DATA_SZ-1:DATA_SZ], a_q[DATA_SZ-1]};
    rem_diff  = {1'b0, rem_sh} - {2'b00, b_q};
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[DATA_SZ-1:0] : acc_q[DATA_SZ-1:0];
    rem_fix   = dneg_q ? -acc_q[2*DATA_SZ-1:DATA_SZ] : acc_q[2*DATA_SZ-1:DATA_SZ];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    araw_d   = araw_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    dneg_d   = dneg_q;
    bzero_d  = bzero_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a_d      = a_mag;
          b_d      = b_mag;
          araw_d   = i_rs_data;
          is_div_d = i_op[1];
          neg_d    = is_signed & (i_rs_data[DATA_SZ-1] ^ i_rt_data[DATA_SZ-1]);
          dneg_d   = is_signed & i_rs_data[DATA_SZ-1];
          bzero_d  = (i_rt_data == '0);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          if (i_mthi) hi_d = i_rs_data;
          if (i_mtlo) lo_d = i_rs_data;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_d = rem_diff[DATA_SZ+1]
                ? {rem_sh[DATA_SZ-1:0], acc_q[DATA_SZ-2:0], 1'b0}
                : {rem_diff[DATA_SZ-1:0], acc_q[DATA_SZ-2:0], 1'b1};
          a_d   = a_q << 1;
        end else begin
          acc_d = {mul_sum, acc_q[DATA_SZ-1:1]};
          b_d   = b_q >> 1;
        end
        if (cnt_q == CW'(DATA_SZ - 1)) state_d = S_FIN;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      S_FIN: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (bzero_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      araw_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      dneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      done_q   <= 1'b0;
    end else if (i_enable) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      araw_q   <= araw_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      dneg_q   <= dneg_d;
      bzero_q  <= bzero_d;
      done_q   <= done_d;
    end
  end

  // Handshake: o_stall asks upstream to hold its instruction; anything presented while busy is ignored.
  assign o_hi    = hi_q;
  assign o_lo    = lo_q;
  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = done_q;
  assign o_stall = o_busy && (i_start || i_hilo_read || i_mthi || i_mtlo);
  assign o_state = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: scoreboard of expected {HI,LO} values checked on o_done.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_start, i_hilo_read, i_mthi, i_mtlo;
  logic [1:0]  i_op;
  logic [31:0] i_rs_data, i_rt_data;
  logic [31:0] o_hi, o_lo;
  logic        o_busy, o_done, o_stall;
  logic [1:0]  o_state;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ex_muldiv_unit #(.DATA_SZ(32)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_start(i_start),
    .i_op(i_op), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .i_hilo_read(i_hilo_read), .i_mthi(i_mthi), .i_mtlo(i_mtlo),
    .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy), .o_done(o_done),
    .o_stall(o_stall), .o_state(o_state)
  );

  // Reference result {HI,LO} computed with native 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    logic signed [63:0] sa64, sb64, sp;
    sa = a;
    sb = b;
    sa64 = sa;
    sb64 = sb;
    case (op)
      2'b00: begin
        sp = sa64 * sb64;
        return sp;
      end
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    i_start   = 1'b1;
    i_op      = op;
    i_rs_data = a;
    i_rt_data = b;
    #1 check("stall_on_idle_issue", o_stall, 0);
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    int g;
    n = 0;
    g = 0;
    while (!o_done && g < 300) begin
      g++;
      if (o_busy) n++;
      @(negedge clk);
    end
    check("done_seen", o_done, 1);
  endtask

  task automatic compare_result(input string tag);
    logic [63:0] e;
    check("sb_nonempty", 64'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, {o_hi, o_lo}, e);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    issue(op, a, b);
    wait_done(n);
    check("busy_cycles", n, 33);
    compare_result(tag);
    @(negedge clk);
    check("done_one_cycle", o_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g;
    i_reset = 1'b1; i_enable = 1'b1; i_start = 1'b0; i_op = 2'b00;
    i_rs_data = '0; i_rt_data = '0; i_hilo_read = 1'b0; i_mthi = 1'b0; i_mtlo = 1'b0;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    check("reset_hi", o_hi, 0);
    check("reset_lo", o_lo, 0);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_state", o_state, 0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_zero_signed", 2'b10, 32'hFFFF_FF00, 32'd0);
    run_op("mult_both_neg", 2'b00, 32'h8000_0000, 32'h8000_0000);
    run_op("div_rem_neg", 2'b10, 32'd17, 32'hFFFF_FFFB);
    for (int k = 0; k < 4; k++)
      run_op("rand_op", 2'(k), $urandom_range(32'hFFFF_FFFF, 0), $urandom_range(32'hFFFF_FFFF, 1));

    // Dependent read arrives while busy, plus a stray restart attempt.
    issue(2'b11, 32'd100, 32'd7);
    i_hilo_read = 1'b1;
    g = 0;
    while (o_busy && g < 100) begin
      if (g == 4) begin
        i_start = 1'b1; i_op = 2'b01; i_rs_data = 32'd5; i_rt_data = 32'd5;
      end else begin
        i_start = 1'b0;
      end
      #1 check("stall_while_busy", o_stall, 1);
      g++;
      @(negedge clk);
    end
    i_start = 1'b0;
    #1 check("stall_drop", o_stall, 0);
    check("stall_cycles", g, 33);
    check("done_after_stall", o_done, 1);
    compare_result("divu_100_7");
    i_hilo_read = 1'b0;
    @(negedge clk);
    check("restart_ignored", o_busy, 0);

    // Freeze 5 cycles mid-RUN.
    issue(2'b00, 32'd12345, 32'hFFFF_FD4A);
    repeat (10) @(negedge clk);
    i_enable = 1'b0;
    repeat (5) @(negedge clk);
    check("frozen_busy", o_busy, 1);
    check("frozen_done", o_done, 0);
    i_enable = 1'b1;
    wait_done(n);
    check("busy_after_freeze", n, 23);
    compare_result("mult_freeze");

    // Reset mid-RUN discards the operation.
    issue(2'b01, 32'hDEAD_BEEF, 32'h0000_1234);
    repeat (5) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    exp_q.delete();
    check("midreset_hi", o_hi, 0);
    check("midreset_lo", o_lo, 0);
    check("midreset_busy", o_busy, 0);
    check("midreset_done", o_done, 0);
    @(negedge clk);
    check("midreset_stays_idle", o_busy, 0);

    // MTHI / MTLO in IDLE.
    i_mthi = 1'b1; i_rs_data = 32'h1234_5678;
    #1 check("mthi_no_stall", o_stall, 0);
    @(negedge clk);
    i_mthi = 1'b0;
    check("mthi_hi", o_hi, 32'h1234_5678);
    check("mthi_lo_kept", o_lo, 0);
    i_mtlo = 1'b1; i_rs_data = 32'hCAFE_BABE;
    #1 check("mtlo_no_stall", o_stall, 0);
    @(negedge clk);
    i_mtlo = 1'b0;
    check("mtlo_lo", o_lo, 32'hCAFE_BABE);
    check("mtlo_hi_kept", o_hi, 32'h1234_5678);
    i_mthi = 1'b1; i_mtlo = 1'b1; i_rs_data = 32'h0F0F_0F0F;
    @(negedge clk);
    i_mthi = 1'b0; i_mtlo = 1'b0;
    check("mtboth", {o_hi, o_lo}, 64'h0F0F_0F0F_0F0F_0F0F);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
